// File: rtl/msrv32_machine_timer_if.sv
// Register-port bundle between the data memory bus decoder and the machine timer.
// The master drives single-cycle requests; the slave returns ack/err/rdata one cycle later.
interface msrv32_machine_timer_if;
    logic        tmr_req_in;
    logic        tmr_wr_in;
    logic [31:0] tmr_addr_in;
    logic [31:0] tmr_wdata_in;
    logic [3:0]  tmr_wr_mask_in;
    logic [31:0] tmr_rdata_out;
    logic        tmr_ack_out;
    logic        tmr_err_out;

    modport master (
        output tmr_req_in, tmr_wr_in, tmr_addr_in, tmr_wdata_in, tmr_wr_mask_in,
        input  tmr_rdata_out, tmr_ack_out, tmr_err_out
    );

    modport slave (
        input  tmr_req_in, tmr_wr_in, tmr_addr_in, tmr_wdata_in, tmr_wr_mask_in,
        output tmr_rdata_out, tmr_ack_out, tmr_err_out
    );
endinterface

// File: rtl/msrv32_machine_timer.sv
// Machine timer: 64-bit mtime/mtimecmp, msip, registered timer and software interrupts.
// Define MSRV32_MTIME_WRITE_EN to make mtime software-writable; otherwise mtime writes return err.
module msrv32_machine_timer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic                   ms_riscv32_mp_clk_in,
    input  logic                   ms_riscv32_mp_rst_in,
    msrv32_machine_timer_if.slave  bus,
    output logic [63:0]            rc_out,
    output logic                   tirq_out,
    output logic                   sirq_out
);

    typedef enum logic {ACK_IDLE, ACK_PEND} ack_state_t;

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    ack_state_t  ack_state;
    ack_state_t  ack_state_nxt;
    logic [15:0] pre_cnt;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:2] word_off;
    logic        sel;
    logic        wr_en;
    logic [2:0]  idx;
    logic        tick;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp_nxt;
    logic        msip_nxt;
    logic [31:0] rd_mux;
    logic        acc_err;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

    // The low two address bits never take part in decoding, so work in word offsets.
    assign word_off  = bus.tmr_addr_in[31:2] - BASE_ADDR[31:2];
    assign sel       = bus.tmr_req_in && (word_off[31:5] == 27'd0);
    assign idx       = word_off[4:2];
    assign wr_en     = sel && bus.tmr_wr_in;
    assign tick      = (pre_cnt == PRESCALE_LAST);
    assign mtime_inc = mtime + 64'(tick);

    // Software writes override only the enabled bytes; the rest follow this cycle's increment.
    always_comb begin
        mtime_nxt    = mtime_inc;
        mtimecmp_nxt = mtimecmp;
        msip_nxt     = msip;
        rd_mux       = 32'd0;
        acc_err      = 1'b0;
        case (idx)
            3'd0: begin
                rd_mux = mtime[31:0];
`ifdef MSRV32_MTIME_WRITE_EN
                if (wr_en)
                    mtime_nxt[31:0] = merge_bytes(mtime_inc[31:0], bus.tmr_wdata_in, bus.tmr_wr_mask_in);
`else
                acc_err = bus.tmr_wr_in;
`endif
            end
            3'd1: begin
                rd_mux = mtime[63:32];
`ifdef MSRV32_MTIME_WRITE_EN
                if (wr_en)
                    mtime_nxt[63:32] = merge_bytes(mtime_inc[63:32], bus.tmr_wdata_in, bus.tmr_wr_mask_in);
`else
                acc_err = bus.tmr_wr_in;
`endif
            end
            3'd2: begin
                rd_mux = mtimecmp[31:0];
                if (wr_en)
                    mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], bus.tmr_wdata_in, bus.tmr_wr_mask_in);
            end
            3'd3: begin
                rd_mux = mtimecmp[63:32];
                if (wr_en)
                    mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], bus.tmr_wdata_in, bus.tmr_wr_mask_in);
            end
            3'd4: begin
                rd_mux = {31'd0, msip};
                if (wr_en && bus.tmr_wr_mask_in[0])
                    msip_nxt = bus.tmr_wdata_in[0];
            end
            default: acc_err = 1'b1;
        endcase
    end

    always_comb begin
        ack_state_nxt = ACK_IDLE;
        if (sel)
            ack_state_nxt = ACK_PEND;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            ack_state <= ACK_IDLE;
            pre_cnt   <= 16'd0;
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip      <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            tirq_out  <= 1'b0;
            sirq_out  <= 1'b0;
        end else begin
            ack_state <= ack_state_nxt;
            pre_cnt   <= tick ? 16'd0 : pre_cnt + 16'd1;
            mtime     <= mtime_nxt;
            mtimecmp  <= mtimecmp_nxt;
            msip      <= msip_nxt;
            rdata_q   <= (sel && !bus.tmr_wr_in) ? rd_mux : 32'd0;
            err_q     <= sel && acc_err;
            tirq_out  <= (mtime >= mtimecmp);
            sirq_out  <= msip;
        end
    end

    assign bus.tmr_ack_out   = (ack_state == ACK_PEND);
    assign bus.tmr_rdata_out = rdata_q;
    assign bus.tmr_err_out   = err_q;
    assign rc_out            = mtime;

endmodule

// File: tb/tb_msrv32_machine_timer.sv
// Randomized self-checking bench for msrv32_machine_timer against a cycle-level reference model.
// A second instance with PRESCALE = 4 runs with an idle bus to check the prescaler.
module tb_msrv32_machine_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef MSRV32_MTIME_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [63:0] rc1;
    logic        tirq1;
    logic        sirq1;
    logic [63:0] rc4;
    logic        tirq4;
    logic        sirq4;

    msrv32_machine_timer_if bus1 ();
    msrv32_machine_timer_if bus4 ();

    msrv32_machine_timer #(.PRESCALE(1), .BASE_ADDR(BASE)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .bus                  (bus1),
        .rc_out               (rc1),
        .tirq_out             (tirq1),
        .sirq_out             (sirq1)
    );

    msrv32_machine_timer #(.PRESCALE(4), .BASE_ADDR(BASE)) dut4 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .bus                  (bus4),
        .rc_out               (rc4),
        .tirq_out             (tirq4),
        .sirq_out             (sirq4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers plus the expected registered outputs.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    bit          m_msip;
    bit          m_tirq;
    bit          m_sirq;
    bit          m_ack;
    bit          m_err;
    logic [31:0] m_rdata;
    int          m_cyc4;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic resetModel();
        m_mtime = 64'd0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip  = 1'b0;
        m_tirq  = 1'b0;
        m_sirq  = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_rdata = 32'd0;
        m_cyc4  = 0;
    endtask

    function automatic logic [31:0] byteWrite(input logic [31:0] old_val, input logic [31:0] data,
                                              input logic [3:0] mask);
        logic [31:0] keep;
        keep = 32'd0;
        for (int b = 0; b < 4; b++)
            if (mask[b]) keep = keep | (32'hFF << (8 * b));
        return (old_val & ~keep) | (data & keep);
    endfunction

    function automatic logic [31:0] readReg(input int r);
        case (r)
            0: return m_mtime[31:0];
            1: return m_mtime[63:32];
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    task automatic applyStimulus(input bit req, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] mask);
        bus1.tmr_req_in     = req;
        bus1.tmr_wr_in      = wr;
        bus1.tmr_addr_in    = addr;
        bus1.tmr_wdata_in   = wdata;
        bus1.tmr_wr_mask_in = mask;
    endtask

    // One clock edge: advance the model from the inputs in force, then compare all outputs.
    task automatic stepCycle();
        logic [31:0] off;
        logic [63:0] nt;
        logic [63:0] nc;
        bit          nm;
        bit          sel;
        int          r;
        @(posedge clk);
        if (rst_n) begin
            off = bus1.tmr_addr_in - BASE;
            sel = bus1.tmr_req_in && (off < 32);
            r   = int'(off >> 2);
            nt  = m_mtime + 64'd1;
            nc  = m_cmp;
            nm  = m_msip;
            m_tirq  = (m_mtime >= m_cmp);
            m_sirq  = m_msip;
            m_ack   = sel;
            m_err   = sel && (r >= 5 || (bus1.tmr_wr_in && r < 2 && !WR_EN));
            m_rdata = (sel && !bus1.tmr_wr_in) ? readReg(r) : 32'd0;
            if (sel && bus1.tmr_wr_in) begin
                case (r)
                    0: if (WR_EN) nt[31:0]  = byteWrite(nt[31:0], bus1.tmr_wdata_in, bus1.tmr_wr_mask_in);
                    1: if (WR_EN) nt[63:32] = byteWrite(nt[63:32], bus1.tmr_wdata_in, bus1.tmr_wr_mask_in);
                    2: nc[31:0]  = byteWrite(nc[31:0], bus1.tmr_wdata_in, bus1.tmr_wr_mask_in);
                    3: nc[63:32] = byteWrite(nc[63:32], bus1.tmr_wdata_in, bus1.tmr_wr_mask_in);
                    4: if (bus1.tmr_wr_mask_in[0]) nm = bus1.tmr_wdata_in[0];
                    default: ;
                endcase
            end
            m_mtime = nt;
            m_cmp   = nc;
            m_msip  = nm;
            m_cyc4++;
        end else begin
            resetModel();
        end
        #1;
        checkOutput("rc", rc1, m_mtime);
        checkOutput("ack", 64'(bus1.tmr_ack_out), 64'(m_ack));
        checkOutput("tirq", 64'(tirq1), 64'(m_tirq));
        checkOutput("sirq", 64'(sirq1), 64'(m_sirq));
        checkOutput("rc_prescale4", rc4, 64'(m_cyc4 / 4));
        if (m_ack) begin
            checkOutput("err", 64'(bus1.tmr_err_out), 64'(m_err));
            checkOutput("rdata", 64'(bus1.tmr_rdata_out), 64'(m_rdata));
        end
    endtask

    task automatic doAccess(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask);
        applyStimulus(1'b1, wr, addr, wdata, mask);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rc"}, rc1, 64'd0);
        checkOutput({tag, "_ack"}, 64'(bus1.tmr_ack_out), 64'd0);
        checkOutput({tag, "_err"}, 64'(bus1.tmr_err_out), 64'd0);
        checkOutput({tag, "_rdata"}, 64'(bus1.tmr_rdata_out), 64'd0);
        checkOutput({tag, "_tirq"}, 64'(tirq1), 64'd0);
        checkOutput({tag, "_sirq"}, 64'(sirq1), 64'd0);
        checkOutput({tag, "_rc4"}, rc4, 64'd0);
    endtask

    initial begin
        logic [31:0] raddr;
        int          bound;
        bus4.tmr_req_in     = 1'b0;
        bus4.tmr_wr_in      = 1'b0;
        bus4.tmr_addr_in    = 32'd0;
        bus4.tmr_wdata_in   = 32'd0;
        bus4.tmr_wr_mask_in = 4'd0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        resetModel();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;

        $display("[TB] idle counting");
        idle(10);
        checkOutput("rc_after_10", rc1, 64'd10);
        checkOutput("tirq_after_10", 64'(tirq1), 64'd0);
        doAccess(1'b0, BASE + 32'h08, 32'd0, 4'd0);
        checkOutput("cmp_lo_reset", 64'(bus1.tmr_rdata_out), 64'hFFFF_FFFF);
        checkOutput("cmp_lo_err", 64'(bus1.tmr_err_out), 64'd0);
        doAccess(1'b0, BASE + 32'h0C, 32'd0, 4'd0);
        checkOutput("cmp_hi_reset", 64'(bus1.tmr_rdata_out), 64'hFFFF_FFFF);
        idle(8);
        checkOutput("rc4_after_20", rc4, 64'd5);

        $display("[TB] compare interrupt");
        doAccess(1'b1, BASE + 32'h08, 32'd50, 4'hF);
        doAccess(1'b1, BASE + 32'h0C, 32'd0, 4'hF);
        bound = 0;
        while (m_mtime != 64'd50 && bound < 200) begin
            stepCycle();
            bound++;
        end
        checkOutput("reach_50", rc1, 64'd50);
        checkOutput("tirq_at_50", 64'(tirq1), 64'd0);
        stepCycle();
        checkOutput("tirq_rise", 64'(tirq1), 64'd1);
        idle(2);
        doAccess(1'b1, BASE + 32'h08, 32'd100, 4'hF);
        stepCycle();
        checkOutput("tirq_fall", 64'(tirq1), 64'd0);

        $display("[TB] mtime write and carry");
        doAccess(1'b1, BASE + 32'h04, 32'h0000_0001, 4'hF);
        checkOutput("mtime_hi_wr_err", 64'(bus1.tmr_err_out), 64'(!WR_EN));
        doAccess(1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
        checkOutput("mtime_lo_wr_err", 64'(bus1.tmr_err_out), 64'(!WR_EN));
        stepCycle();
`ifdef MSRV32_MTIME_WRITE_EN
        checkOutput("carry_into_hi", rc1, 64'h0000_0002_0000_0000);
`endif

        $display("[TB] msip and decode");
        doAccess(1'b1, BASE + 32'h10, 32'd1, 4'b0001);
        stepCycle();
        checkOutput("sirq_set", 64'(sirq1), 64'd1);
        doAccess(1'b1, BASE + 32'h10, 32'd0, 4'b0000);
        stepCycle();
        checkOutput("sirq_mask0_hold", 64'(sirq1), 64'd1);
        doAccess(1'b1, BASE + 32'h10, 32'd0, 4'b0001);
        stepCycle();
        checkOutput("sirq_clear", 64'(sirq1), 64'd0);
        doAccess(1'b0, BASE + 32'h14, 32'd0, 4'd0);
        checkOutput("unmapped_rdata", 64'(bus1.tmr_rdata_out), 64'd0);
        checkOutput("unmapped_err", 64'(bus1.tmr_err_out), 64'd1);
        doAccess(1'b0, 32'h0300_0000, 32'd0, 4'd0);
        checkOutput("outside_no_ack", 64'(bus1.tmr_ack_out), 64'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: raddr = 32'h0300_0000;
                1: raddr = BASE + 32'd32 + 32'($urandom_range(0, 15));
                2: raddr = BASE - 32'd4;
                default: raddr = BASE + 32'($urandom_range(0, 31));
            endcase
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr,
                          $urandom, 4'($urandom_range(0, 15)));
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        stepCycle();

        $display("[TB] reset during pending access");
        if (WR_EN) begin
            doAccess(1'b1, BASE + 32'h04, 32'd0, 4'hF);
            doAccess(1'b1, BASE + 32'h00, 32'd490, 4'hF);
        end
        bound = 0;
        while (m_mtime < 64'd500 && bound < 2000) begin
            stepCycle();
            bound++;
        end
        applyStimulus(1'b1, 1'b1, BASE + 32'h10, 32'd1, 4'b0001);
        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkResetOutputs("async_reset");
        stepCycle();
        checkOutput("ack_suppressed", 64'(bus1.tmr_ack_out), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        stepCycle();
        checkResetOutputs("held_reset");
        rst_n = 1'b1;
        idle(3);
        checkOutput("rc_restart", rc1, 64'd3);
        doAccess(1'b0, BASE + 32'h10, 32'd0, 4'd0);
        checkOutput("msip_not_written", 64'(bus1.tmr_rdata_out), 64'd0);
        doAccess(1'b0, BASE + 32'h0C, 32'd0, 4'd0);
        checkOutput("cmp_hi_after_reset", 64'(bus1.tmr_rdata_out), 64'hFFFF_FFFF);
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
